// File: rtl/sdr_app_arbiter_if.sv
// Bundle of client, controller-app and status signals around sdr_app_arbiter.
// The arbiter takes the slave modport; clients and the SDRAM controller model take master.
interface sdr_app_arbiter_if #(
  parameter int ADDR_WIDTH = 21,
  parameter int DATA_WIDTH = 32,
  parameter int DM_WIDTH   = 4,
  parameter int LEN_WIDTH  = 9
);
  logic                  Sdr_init_done;
  logic                  Sdr_init_ref_vld;
  logic                  W_req;
  logic [ADDR_WIDTH-1:0] W_addr;
  logic [LEN_WIDTH-1:0]  W_len;
  logic [DATA_WIDTH-1:0] W_din;
  logic                  W_ack;
  logic                  W_done;
  logic                  R_req;
  logic [ADDR_WIDTH-1:0] R_addr;
  logic [LEN_WIDTH-1:0]  R_len;
  logic                  R_dout_vld;
  logic [DATA_WIDTH-1:0] R_dout;
  logic                  R_done;
  logic                  App_wr_en;
  logic [ADDR_WIDTH-1:0] App_wr_addr;
  logic [DM_WIDTH-1:0]   App_wr_dm;
  logic [DATA_WIDTH-1:0] App_wr_din;
  logic                  App_rd_en;
  logic [ADDR_WIDTH-1:0] App_rd_addr;
  logic                  Sdr_rd_en;
  logic [DATA_WIDTH-1:0] Sdr_rd_dout;
  logic                  Err;

  // Handshakes: a client raises *_req and holds it (with addr/len stable) until its
  // one-cycle *_done; W_din is consumed on every cycle W_ack is high, and the client
  // presents the next word after that edge. App_*_en, Sdr_rd_en and R_dout_vld are
  // single-cycle valids with no back-pressure.
  modport slave (
    input  Sdr_init_done, Sdr_init_ref_vld,
    input  W_req, W_addr, W_len, W_din,
    output W_ack, W_done,
    input  R_req, R_addr, R_len,
    output R_dout_vld, R_dout, R_done,
    output App_wr_en, App_wr_addr, App_wr_dm, App_wr_din,
    output App_rd_en, App_rd_addr,
    input  Sdr_rd_en, Sdr_rd_dout,
    output Err
  );

  modport master (
    output Sdr_init_done, Sdr_init_ref_vld,
    output W_req, W_addr, W_len, W_din,
    input  W_ack, W_done,
    output R_req, R_addr, R_len,
    input  R_dout_vld, R_dout, R_done,
    input  App_wr_en, App_wr_addr, App_wr_dm, App_wr_din,
    input  App_rd_en, App_rd_addr,
    output Sdr_rd_en, Sdr_rd_dout,
    input  Err
  );
endinterface

// File: rtl/sdr_app_arbiter.sv
// Two-client (write/read) burst arbiter in front of the SDRAM controller app port,
// with refresh hold-off, outstanding-read tracking and a sticky drain-timeout error.
module sdr_app_arbiter #(
  parameter int ADDR_WIDTH = 21,
  parameter int DATA_WIDTH = 32,
  parameter int DM_WIDTH   = 4,
  parameter int LEN_WIDTH  = 9,
  parameter int DRAIN_TMO  = 255
) (
  input  logic             Clk,
  input  logic             Rst,
  sdr_app_arbiter_if.slave bus,
  output logic [1:0]       dbg_state
);
  localparam int TMO_W = $clog2(DRAIN_TMO + 1);
  localparam int OUT_W = LEN_WIDTH + 1;
  localparam logic SRV_W = 1'b0;
  localparam logic SRV_R = 1'b1;

  typedef enum logic [1:0] {IDLE = 2'd0, WR = 2'd1, RD = 2'd2, RD_DRAIN = 2'd3} state_t;

  state_t                state_q, state_d;
  logic                  last_q, last_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [LEN_WIDTH-1:0]  beat_q, beat_d;
  logic [OUT_W-1:0]      out_q, out_d;
  logic [TMO_W-1:0]      tmo_q, tmo_d;
  logic                  err_q, err_d;
  logic                  wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0] wr_din_q, wr_din_d;
  logic                  rd_en_q, rd_en_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic                  r_vld_q, r_vld_d;
  logic [DATA_WIDTH-1:0] r_dout_q, r_dout_d;
  logic                  w_done_q, w_done_d;
  logic                  r_done_q, r_done_d;

  logic                  w_ack, issue, clr_out, can_go;
  logic                  w_want, r_want, grant_w, grant_r;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [TMO_W-1:0]      tmo_inc;

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    addr_d    = addr_q;
    len_d     = len_q;
    beat_d    = beat_q;
    tmo_d     = '0;
    err_d     = err_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_din_d  = wr_din_q;
    rd_en_d   = 1'b0;
    rd_addr_d = rd_addr_q;
    r_vld_d   = bus.Sdr_rd_en;
    r_dout_d  = bus.Sdr_rd_dout;
    w_done_d  = 1'b0;
    r_done_d  = 1'b0;
    issue     = 1'b0;
    clr_out   = 1'b0;

    cur_addr = addr_q + ADDR_WIDTH'(beat_q);
    tmo_inc  = tmo_q + TMO_W'(1);
    can_go   = bus.Sdr_init_done && !bus.Sdr_init_ref_vld;
    // A client is invisible during its own done cycle, so a held req is a fresh request.
    w_want   = bus.W_req && !w_done_q;
    r_want   = bus.R_req && !r_done_q;
    grant_w  = w_want && (!r_want || last_q == SRV_R);
    grant_r  = r_want && !grant_w;
    w_ack    = (state_q == WR) && !bus.Sdr_init_ref_vld && (beat_q < len_q);

    unique case (state_q)
      IDLE: begin
        if (can_go && (grant_w || grant_r)) begin
          last_d = grant_w ? SRV_W : SRV_R;
          addr_d = grant_w ? bus.W_addr : bus.R_addr;
          len_d  = grant_w ? bus.W_len : bus.R_len;
          beat_d = '0;
          if (len_d == '0) begin
            w_done_d = grant_w;
            r_done_d = grant_r;
          end else begin
            state_d = grant_w ? WR : RD;
          end
        end
      end
      WR: begin
        if (beat_q == len_q) begin
          w_done_d = 1'b1;
          state_d  = IDLE;
        end else if (w_ack) begin
          wr_en_d   = 1'b1;
          wr_addr_d = cur_addr;
          wr_din_d  = bus.W_din;
          beat_d    = beat_q + LEN_WIDTH'(1);
        end
      end
      RD: begin
        if (!bus.Sdr_init_ref_vld) begin
          rd_en_d   = 1'b1;
          rd_addr_d = cur_addr;
          issue     = 1'b1;
          beat_d    = beat_q + LEN_WIDTH'(1);
          if (beat_d == len_q) state_d = RD_DRAIN;
        end
      end
      RD_DRAIN: begin
        tmo_d = tmo_inc;
        if (out_q == '0) begin
          r_done_d = 1'b1;
          state_d  = IDLE;
        end else if (tmo_inc == TMO_W'(DRAIN_TMO)) begin
          err_d    = 1'b1;
          clr_out  = 1'b1;
          r_done_d = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Returns never take the counter below zero (late data after reset or timeout).
    out_d = out_q;
    if (clr_out) out_d = '0;
    else if (issue && !bus.Sdr_rd_en) out_d = out_q + OUT_W'(1);
    else if (!issue && bus.Sdr_rd_en && out_q != '0) out_d = out_q - OUT_W'(1);
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q   <= IDLE;
      last_q    <= SRV_R;
      addr_q    <= '0;
      len_q     <= '0;
      beat_q    <= '0;
      out_q     <= '0;
      tmo_q     <= '0;
      err_q     <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_din_q  <= '0;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      r_vld_q   <= 1'b0;
      r_dout_q  <= '0;
      w_done_q  <= 1'b0;
      r_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      beat_q    <= beat_d;
      out_q     <= out_d;
      tmo_q     <= tmo_d;
      err_q     <= err_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_din_q  <= wr_din_d;
      rd_en_q   <= rd_en_d;
      rd_addr_q <= rd_addr_d;
      r_vld_q   <= r_vld_d;
      r_dout_q  <= r_dout_d;
      w_done_q  <= w_done_d;
      r_done_q  <= r_done_d;
    end
  end

  assign bus.W_ack       = w_ack;
  assign bus.W_done      = w_done_q;
  assign bus.R_dout_vld  = r_vld_q;
  assign bus.R_dout      = r_dout_q;
  assign bus.R_done      = r_done_q;
  assign bus.App_wr_en   = wr_en_q;
  assign bus.App_wr_addr = wr_addr_q;
  assign bus.App_wr_dm   = {DM_WIDTH{1'b0}};
  assign bus.App_wr_din  = wr_din_q;
  assign bus.App_rd_en   = rd_en_q;
  assign bus.App_rd_addr = rd_addr_q;
  assign bus.Err         = err_q;
  assign dbg_state       = state_q;
endmodule

// File: tb/tb_sdr_app_arbiter.sv
// Bench for sdr_app_arbiter: client drivers, an SDRAM controller model with fixed
// read latency, and a scoreboard of expected app beats, read data and done order.
`timescale 1ns/1ps
module tb_sdr_app_arbiter;
  localparam int AW  = 21;
  localparam int DW  = 32;
  localparam int DMW = 4;
  localparam int LW  = 9;
  localparam int TMO = 255;
  localparam int RD_LAT = 3;

  typedef struct { int due; logic [DW-1:0] d; } pend_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] dbg_state;
  int         cyc = 0;

  sdr_app_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DM_WIDTH(DMW), .LEN_WIDTH(LW)) bus ();

  sdr_app_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DM_WIDTH(DMW), .LEN_WIDTH(LW),
                    .DRAIN_TMO(TMO)) dut (
    .Clk(clk), .Rst(rst), .bus(bus), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state
  int compared = 0;
  int mismatched = 0;
  logic [AW+DW-1:0] wr_exp_q[$];
  logic [AW-1:0]    rd_addr_exp_q[$];
  logic [DW-1:0]    rd_exp_q[$];
  logic             done_exp_q[$];
  logic [DW-1:0]    exp_mem[int];
  logic [DW-1:0]    dev_mem[int];
  pend_t            pend_q[$];
  logic             exp_err = 1'b0;
  int wack_cnt = 0, wen_cnt = 0, ren_cnt = 0;
  int first_wack_cyc = -1, first_wen_cyc = -1;
  int wen_cyc_q[$];
  int last_ren_cyc = 0, rdone_cyc = 0;
  int ret_limit = -1, ret_cnt = 0;
  bit rnd_ref_en = 0, ref_req = 0;
  int ref_hold = 0;

  function automatic void check(input string nm, input logic [63:0] act, input logic [63:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: actual %0h required %0h (cycle %0d)", nm, act, req, cyc);
    end
  endfunction

  function automatic void check_range(input string nm, input int act, input int lo, input int hi);
    compared++;
    if (act < lo || act > hi) begin
      mismatched++;
      $display("FAIL %s: actual %0d required %0d..%0d", nm, act, lo, hi);
    end
  endfunction

  function automatic void fail_now(input string nm);
    compared++;
    mismatched++;
    $display("FAIL %s: event seen with nothing expected (cycle %0d)", nm, cyc);
  endfunction

  // Contents of a never-written location, shared by device and reference.
  function automatic logic [DW-1:0] dflt(input logic [AW-1:0] a);
    return {11'h2A5, a};
  endfunction

  // ---------------- monitor: pops expectations whenever the DUT presents something
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.W_ack) begin
        wack_cnt++;
        if (first_wack_cyc < 0) first_wack_cyc = cyc;
      end
      if (bus.App_wr_en || bus.App_rd_en)
        check("en_overlap", {63'd0, bus.App_wr_en & bus.App_rd_en}, 64'd0);
      if (bus.App_wr_en) begin
        wen_cnt++;
        wen_cyc_q.push_back(cyc);
        if (first_wen_cyc < 0) first_wen_cyc = cyc;
        dev_mem[int'(bus.App_wr_addr)] = bus.App_wr_din;
        check("wr_dm", {60'd0, bus.App_wr_dm}, 64'd0);
        if (wr_exp_q.size() == 0) fail_now("wr_unexpected");
        else check("wr_beat", {bus.App_wr_addr, bus.App_wr_din}, wr_exp_q.pop_front());
      end
      if (bus.App_rd_en) begin
        ren_cnt++;
        last_ren_cyc = cyc;
        if (rd_addr_exp_q.size() == 0) fail_now("rd_unexpected");
        else check("rd_addr", bus.App_rd_addr, rd_addr_exp_q.pop_front());
        if (ret_limit < 0 || ret_cnt < ret_limit) begin
          pend_t p;
          p.due = cyc + RD_LAT;
          p.d = dev_mem.exists(int'(bus.App_rd_addr)) ? dev_mem[int'(bus.App_rd_addr)]
                                                      : dflt(bus.App_rd_addr);
          pend_q.push_back(p);
        end
        ret_cnt++;
      end
      if (bus.R_dout_vld) begin
        if (rd_exp_q.size() == 0) fail_now("rdata_unexpected");
        else check("rdata", bus.R_dout, rd_exp_q.pop_front());
      end
      if (bus.W_done || bus.R_done) begin
        if (bus.R_done) begin
          rdone_cyc = cyc;
          check("r_done_err", {63'd0, bus.Err}, {63'd0, exp_err});
        end
        if (bus.W_done && bus.R_done) fail_now("both_done");
        else if (done_exp_q.size() == 0) fail_now("done_unexpected");
        else check("done_client", {63'd0, bus.R_done}, {63'd0, done_exp_q.pop_front()});
      end
    end
  end

  // ---------------- controller model: read data RD_LAT cycles after App_rd_en
  initial begin
    bus.Sdr_rd_en = 1'b0;
    bus.Sdr_rd_dout = '0;
    forever begin
      @(posedge clk); #1;
      if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
        pend_t p;
        p = pend_q.pop_front();
        bus.Sdr_rd_en = 1'b1;
        bus.Sdr_rd_dout = p.d;
      end else begin
        bus.Sdr_rd_en = 1'b0;
        bus.Sdr_rd_dout = $urandom;
      end
    end
  end

  // ---------------- refresh window driver (directed request or random)
  initial begin
    bus.Sdr_init_ref_vld = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (ref_req) begin
        ref_req = 0;
        ref_hold = 5;
      end else if (ref_hold == 0 && rnd_ref_en && $urandom_range(0, 19) == 0) begin
        ref_hold = int'($urandom_range(1, 4));
      end
      bus.Sdr_init_ref_vld = (ref_hold > 0);
      if (ref_hold > 0) ref_hold--;
    end
  end

  // ---------------- client driver tasks (called at posedge + #1)
  task automatic wr_burst(input logic [AW-1:0] a, input int len, input logic [DW-1:0] d0,
                          input bit rnd, input bit push_done);
    logic [DW-1:0] dq[$];
    logic [DW-1:0] d;
    logic [AW-1:0] ai;
    bit ack, dn;
    int k, guard;
    for (int i = 0; i < len; i++) begin
      d = rnd ? DW'($urandom) : d0 + DW'(i);
      ai = a + AW'(i);
      dq.push_back(d);
      wr_exp_q.push_back({ai, d});
      exp_mem[int'(ai)] = d;
    end
    if (push_done) done_exp_q.push_back(1'b0);
    bus.W_addr = a;
    bus.W_len = LW'(len);
    bus.W_din = (len > 0) ? dq[0] : '0;
    bus.W_req = 1'b1;
    k = 0; guard = 0; dn = 0;
    while (!dn && guard < 3000) begin
      @(negedge clk);
      ack = bus.W_ack;
      dn = bus.W_done;
      @(posedge clk); #1;
      guard++;
      if (ack) begin
        k++;
        bus.W_din = (k < len) ? dq[k] : DW'($urandom);
      end
    end
    if (!dn) begin
      compared++; mismatched++;
      $display("FAIL wr_done_timeout: actual no W_done required W_done within 3000 cycles");
    end
    bus.W_req = 1'b0;
  endtask

  task automatic rd_burst(input logic [AW-1:0] a, input int len, input int nret, input bit push_done);
    logic [AW-1:0] ai;
    bit dn;
    int guard;
    for (int i = 0; i < len; i++) begin
      ai = a + AW'(i);
      rd_addr_exp_q.push_back(ai);
      if (i < nret) rd_exp_q.push_back(exp_mem.exists(int'(ai)) ? exp_mem[int'(ai)] : dflt(ai));
    end
    if (push_done) done_exp_q.push_back(1'b1);
    bus.R_addr = a;
    bus.R_len = LW'(len);
    bus.R_req = 1'b1;
    guard = 0; dn = 0;
    while (!dn && guard < 3000) begin
      @(negedge clk);
      dn = bus.R_done;
      @(posedge clk); #1;
      guard++;
    end
    if (!dn) begin
      compared++; mismatched++;
      $display("FAIL rd_done_timeout: actual no R_done required R_done within 3000 cycles");
    end
    bus.R_req = 1'b0;
  endtask

  // ---------------- main sequence
  initial begin
    int t_init, w0, r0, n0, max_gap;
    logic [AW-1:0] a;
    int len;
    bus.Sdr_init_done = 1'b0;
    bus.W_req = 1'b0; bus.W_addr = '0; bus.W_len = '0; bus.W_din = '0;
    bus.R_req = 1'b0; bus.R_addr = '0; bus.R_len = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    check("rst_wr_en", {63'd0, bus.App_wr_en}, 64'd0);
    check("rst_rd_en", {63'd0, bus.App_rd_en}, 64'd0);
    check("rst_w_ack", {63'd0, bus.W_ack}, 64'd0);
    check("rst_dones", {62'd0, bus.W_done, bus.R_done}, 64'd0);
    check("rst_rvld", {63'd0, bus.R_dout_vld}, 64'd0);
    check("rst_err", {63'd0, bus.Err}, 64'd0);
    check("rst_state", {62'd0, dbg_state}, 64'd0);
    @(posedge clk); #1;

    // Init gating: W_req held with init_done low, then released.
    t_init = 0;
    fork
      wr_burst(21'h100, 4, 32'd1, 0, 1);
      begin
        repeat (50) @(posedge clk);
        #1;
        check("gate_no_wr_en", 64'(wen_cnt), 64'd0);
        check("gate_no_ack", 64'(wack_cnt), 64'd0);
        bus.Sdr_init_done = 1'b1;
        t_init = cyc;
      end
    join
    check_range("init_ack_latency", first_wack_cyc - t_init, 1, 2);
    check_range("init_wen_latency", first_wen_cyc - t_init, 1, 2);

    // Read back what was written (data 1..4).
    rd_burst(21'h100, 4, 4, 1);
    check("rd_err_clear", {63'd0, bus.Err}, 64'd0);

    // Contention: last served is R, so W wins the tie, then strict alternation.
    done_exp_q.push_back(1'b0); done_exp_q.push_back(1'b1);
    done_exp_q.push_back(1'b0); done_exp_q.push_back(1'b1);
    fork
      begin wr_burst(21'h1000, 2, 0, 1, 0); wr_burst(21'h1002, 2, 0, 1, 0); end
      begin rd_burst(21'h8000, 2, 2, 0); rd_burst(21'h8002, 2, 2, 0); end
    join

    // Refresh window of 5 cycles after the second accepted beat of an 8-beat write.
    w0 = wack_cnt;
    n0 = wen_cyc_q.size();
    fork
      wr_burst(21'h3000, 8, 0, 1, 1);
      begin
        int g = 0;
        while (wack_cnt < w0 + 2 && g < 200) begin @(posedge clk); g++; end
        ref_req = 1;
      end
    join
    check("ref_wr_beats", 64'(wen_cyc_q.size() - n0), 64'd8);
    max_gap = 0;
    for (int i = n0 + 1; i < wen_cyc_q.size(); i++)
      if (wen_cyc_q[i] - wen_cyc_q[i-1] > max_gap) max_gap = wen_cyc_q[i] - wen_cyc_q[i-1];
    check("ref_gap", 64'(max_gap), 64'd6);

    // Drain timeout: controller returns only the first of two beats.
    exp_err = 1'b1;
    ret_cnt = 0;
    ret_limit = 1;
    rd_burst(21'h4000, 2, 1, 1);
    check_range("drain_tmo_cycles", rdone_cyc - last_ren_cyc, TMO, TMO + 2);
    check("err_sticky", {63'd0, bus.Err}, 64'd1);
    ret_limit = -1;
    wr_burst(21'h4100, 3, 0, 1, 1);
    w0 = wen_cnt; r0 = ren_cnt;
    wr_burst(21'h4200, 0, 0, 1, 1);
    rd_burst(21'h4300, 0, 0, 1);
    check("zero_len_wr_en", 64'(wen_cnt - w0), 64'd0);
    check("zero_len_rd_en", 64'(ren_cnt - r0), 64'd0);

    // Full-length bursts across the top of the address space.
    wr_burst(21'h1FFF80, 256, 0, 1, 1);
    rd_burst(21'h1FFF80, 256, 256, 1);

    // Random bursts with random refresh windows.
    rnd_ref_en = 1;
    for (int it = 0; it < 40; it++) begin
      a = ($urandom_range(0, 3) == 0) ? AW'(21'h1FFFF8 + $urandom_range(0, 7)) : AW'($urandom);
      len = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, 16));
      if ($urandom_range(0, 1) == 0) wr_burst(a, len, 0, 1, 1);
      else rd_burst(a, len, len, 1);
    end
    rnd_ref_en = 0;

    repeat (10) @(posedge clk);
    @(negedge clk);
    check("left_wr", 64'(wr_exp_q.size()), 64'd0);
    check("left_rd_addr", 64'(rd_addr_exp_q.size()), 64'd0);
    check("left_rdata", 64'(rd_exp_q.size()), 64'd0);
    check("left_done", 64'(done_exp_q.size()), 64'd0);
    check("final_err", {63'd0, bus.Err}, 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: actual simulation still running required completion before 2ms");
    $fatal(1, "watchdog expired");
  end
endmodule
